// File: rtl/l15_amo_requester_pkg.sv
// Shared encodings for the L1.5 AMO requester: opcode/size codes, line
// geometry, FSM state encoding and small byte-lane helpers.
package l15_amo_requester_pkg;

    localparam int L2_AMO_ALU_OP_WIDTH     = 4;
    localparam int PHY_ADDR_WIDTH          = 40;
    localparam int MSG_DATA_SIZE_WIDTH     = 3;
    localparam int L2_DATA_DATA_WIDTH      = 128;
    localparam int L2_DATA_DATA_WIDTH_LOG2 = 7;

    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_OP_NOP  = 4'd0;
    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_OP_ADD  = 4'd1;
    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_OP_AND  = 4'd2;
    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_OP_OR   = 4'd3;
    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_OP_XOR  = 4'd4;
    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_OP_MAX  = 4'd5;
    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_OP_MAXU = 4'd6;
    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_OP_MIN  = 4'd7;
    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_OP_MINU = 4'd8;
    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_OP_SWAP = 4'd9;

    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_0B = 3'd0;
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_1B = 3'd1;
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_2B = 3'd2;
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_4B = 3'd3;
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_8B = 3'd4;

    typedef enum logic [1:0] {
        L15_AMO_REQ_ST_IDLE  = 2'd0,
        L15_AMO_REQ_ST_ISSUE = 2'd1,
        L15_AMO_REQ_ST_WAIT  = 2'd2,
        L15_AMO_REQ_ST_RESP  = 2'd3
    } l15_amo_req_st_e;

    // Access width in bytes; 0 flags an unsupported size code.
    function automatic logic [3:0] size_bytes(input logic [MSG_DATA_SIZE_WIDTH-1:0] sz);
        case (sz)
            MSG_DATA_SIZE_1B: size_bytes = 4'd1;
            MSG_DATA_SIZE_2B: size_bytes = 4'd2;
            MSG_DATA_SIZE_4B: size_bytes = 4'd4;
            MSG_DATA_SIZE_8B: size_bytes = 4'd8;
            default:          size_bytes = 4'd0;
        endcase
    endfunction

    // Misaligned address or unsupported size: the request never reaches the NoC.
    function automatic logic req_err(input logic [2:0] a, input logic [MSG_DATA_SIZE_WIDTH-1:0] sz);
        case (sz)
            MSG_DATA_SIZE_1B: req_err = 1'b0;
            MSG_DATA_SIZE_2B: req_err = a[0];
            MSG_DATA_SIZE_4B: req_err = |a[1:0];
            MSG_DATA_SIZE_8B: req_err = |a;
            default:          req_err = 1'b1;
        endcase
    endfunction

    function automatic logic [63:0] bswap64(input logic [63:0] d);
        for (int i = 0; i < 8; i++) bswap64[8*i +: 8] = d[8*(7-i) +: 8];
    endfunction

endpackage

// File: rtl/l15_amo_lane_fmt.sv
// Combinational lane formatter between a right-justified core operand and an
// L2 data line. UNPACK=0 places the operand in its dword lane (line out);
// UNPACK=1 pulls the addressed field out of a line and sign-extends it.
module l15_amo_lane_fmt
    import l15_amo_requester_pkg::*;
#(
    parameter bit SWAP_ENDIANESS = 1'b1,
    parameter int LINE_WIDTH     = L2_DATA_DATA_WIDTH,
    parameter bit UNPACK         = 1'b0,
    parameter int OFF_W          = $clog2(LINE_WIDTH) - 3,
    parameter int IN_W           = UNPACK ? LINE_WIDTH : 64,
    parameter int OUT_W          = UNPACK ? 64 : LINE_WIDTH
) (
    input  logic [OFF_W-1:0]               off_i,
    input  logic [MSG_DATA_SIZE_WIDTH-1:0] size_i,
    input  logic [IN_W-1:0]                data_i,
    output logic [OUT_W-1:0]               data_o
);
    logic [2:0]  k;
    logic [3:0]  nb;
    int unsigned d;

    assign k  = off_i[2:0];
    assign nb = size_bytes(size_i);
    assign d  = int'(off_i >> 3);

    if (!UNPACK) begin : g_pack
        logic [63:0] dw;
        // Drop the operand bytes at byte offset k of dword d, optionally byte-reversed.
        always_comb begin
            dw = '0;
            for (int b = 0; b < 8; b++)
                if (b >= int'(k) && b < int'(k) + int'(nb))
                    dw[8*b +: 8] = data_i[8*(b - int'(k)) +: 8];
            if (SWAP_ENDIANESS) dw = bswap64(dw);
            data_o = '0;
            data_o[64*d +: 64] = dw;
        end
    end else begin : g_unpack
        logic [63:0] dw;
        logic [63:0] v;
        logic        sgn;
        // Select dword d, undo the byte order, shift the field down and sign-extend.
        always_comb begin
            dw = data_i[64*d +: 64];
            if (SWAP_ENDIANESS) dw = bswap64(dw);
            v   = dw >> {k, 3'b000};
            sgn = 1'b0;
            if (nb != 4'd0) sgn = v[8*int'(nb) - 1];
            data_o = '0;
            for (int b = 0; b < 8; b++)
                data_o[8*b +: 8] = (b < int'(nb)) ? v[8*b +: 8] : {8{sgn}};
        end
    end

endmodule

// File: rtl/l15_amo_requester.sv
// Core-side AMO initiator: accepts one atomic from the core, formats the
// operand into the L2 line layout, issues it, waits for the old line and
// returns the sign-extended old value (or an error) to the core.
module l15_amo_requester
    import l15_amo_requester_pkg::*;
#(
    parameter bit SWAP_ENDIANESS = 1'b1,
    parameter int LINE_WIDTH     = L2_DATA_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           core_req_val_i,
    output logic                           core_req_rdy_o,
    input  logic [L2_AMO_ALU_OP_WIDTH-1:0] core_req_op_i,
    input  logic [PHY_ADDR_WIDTH-1:0]      core_req_addr_i,
    input  logic [MSG_DATA_SIZE_WIDTH-1:0] core_req_size_i,
    input  logic [63:0]                    core_req_data_i,
    output logic                           noc_req_val_o,
    input  logic                           noc_req_rdy_i,
    output logic [L2_AMO_ALU_OP_WIDTH-1:0] noc_req_op_o,
    output logic [PHY_ADDR_WIDTH-1:0]      noc_req_addr_o,
    output logic [MSG_DATA_SIZE_WIDTH-1:0] noc_req_size_o,
    output logic [LINE_WIDTH-1:0]          noc_req_data_o,
    input  logic                           noc_resp_val_i,
    input  logic [LINE_WIDTH-1:0]          noc_resp_data_i,
    output logic                           core_resp_val_o,
    input  logic                           core_resp_rdy_i,
    output logic [63:0]                    core_resp_data_o,
    output logic                           core_resp_err_o
);
    localparam int OFF_W = $clog2(LINE_WIDTH) - 3;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    l15_amo_req_st_e state_q, state_d;
    logic [L2_AMO_ALU_OP_WIDTH-1:0] op_q;
    logic [PHY_ADDR_WIDTH-1:0]      addr_q;
    logic [MSG_DATA_SIZE_WIDTH-1:0] size_q;
    logic [LINE_WIDTH-1:0]          line_q;
    logic [63:0]                    rdata_q;
    logic                           err_q;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    logic                  req_bad;
    logic                  to_hit;
    logic [LINE_WIDTH-1:0] pack_line;
    logic [63:0]           unp_val;

    assign req_bad = req_err(core_req_addr_i[2:0], core_req_size_i);
    assign to_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    l15_amo_lane_fmt #(.SWAP_ENDIANESS(SWAP_ENDIANESS), .LINE_WIDTH(LINE_WIDTH), .UNPACK(1'b0)) u_pack (
        .off_i  (core_req_addr_i[OFF_W-1:0]),
        .size_i (core_req_size_i),
        .data_i (core_req_data_i),
        .data_o (pack_line)
    );

    l15_amo_lane_fmt #(.SWAP_ENDIANESS(SWAP_ENDIANESS), .LINE_WIDTH(LINE_WIDTH), .UNPACK(1'b1)) u_unpack (
        .off_i  (addr_q[OFF_W-1:0]),
        .size_i (size_q),
        .data_i (noc_resp_data_i),
        .data_o (unp_val)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= L15_AMO_REQ_ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: errors short-circuit to RESP; a response beats a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            L15_AMO_REQ_ST_IDLE:  if (core_req_val_i)
                                      state_d = req_bad ? L15_AMO_REQ_ST_RESP : L15_AMO_REQ_ST_ISSUE;
            L15_AMO_REQ_ST_ISSUE: if (noc_req_rdy_i) state_d = L15_AMO_REQ_ST_WAIT;
            L15_AMO_REQ_ST_WAIT:  if (noc_resp_val_i || to_hit) state_d = L15_AMO_REQ_ST_RESP;
            L15_AMO_REQ_ST_RESP:  if (core_resp_rdy_i) state_d = L15_AMO_REQ_ST_IDLE;
            default:              state_d = L15_AMO_REQ_ST_IDLE;
        endcase
    end

    // Handshake outputs decoded purely from state.
    always_comb begin
        core_req_rdy_o  = 1'b0;
        noc_req_val_o   = 1'b0;
        core_resp_val_o = 1'b0;
        unique case (state_q)
            L15_AMO_REQ_ST_IDLE:  core_req_rdy_o  = 1'b1;
            L15_AMO_REQ_ST_ISSUE: noc_req_val_o   = 1'b1;
            L15_AMO_REQ_ST_RESP:  core_resp_val_o = 1'b1;
            default: ;
        endcase
    end

    // Response-wait counter: cleared on issue, saturating while waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == L15_AMO_REQ_ST_ISSUE && noc_req_rdy_i) cnt_d = '0;
        else if (state_q == L15_AMO_REQ_ST_WAIT && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Request fields and formatted line latched on accept; result latched on response/timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state_q == L15_AMO_REQ_ST_IDLE && core_req_val_i) begin
            op_q    <= core_req_op_i;
            addr_q  <= core_req_addr_i;
            size_q  <= core_req_size_i;
            line_q  <= req_bad ? '0 : pack_line;
            rdata_q <= '0;
            err_q   <= req_bad;
        end else if (state_q == L15_AMO_REQ_ST_WAIT) begin
            if (noc_resp_val_i) begin
                rdata_q <= unp_val;
                err_q   <= 1'b0;
            end else if (to_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign noc_req_op_o     = op_q;
    assign noc_req_addr_o   = addr_q;
    assign noc_req_size_o   = size_q;
    assign noc_req_data_o   = line_q;
    assign core_resp_data_o = rdata_q;
    assign core_resp_err_o  = err_q;

endmodule
